// File: rtl/mc_control_unit.sv
// mc_control_unit
//
// Multi-cycle control FSM for a small RV32 core. It sequences FETCH, DECODE,
// EXEC, MEM and WB, and drives the datapath selects and write enables for
// each of these states. Unsupported encodings and memory timeouts land in an
// absorbing TRAP state, which can only be left through reset.
//
// Parameters
//   N        instruction width (>= 32); only instr[31:0] is decoded
//   TIMEOUT  maximum memory-wait cycles in FETCH/MEM; 0 disables the timeout
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   instr         instruction from the external IR, stable from DECODE on
//   mem_ready     memory completes the current request this cycle
//   branch_taken  ALU compare result, sampled in EXEC
//   pc_write      PC write enable
//   ir_write      IR write enable
//   reg_write     register file write enable
//   mem_req       memory request
//   mem_we        memory write qualifier
//   mem_addr_sel  memory address: 0 = PC, 1 = ALU result
//   alu_src_a     ALU A: 00 = rs1, 01 = PC, 10 = zero
//   alu_src_b     ALU B: 00 = rs2, 01 = imm, 10 = constant 4
//   alu_op        00 = add, 01 = compare, 10 = funct-decoded
//   save_method   store width: 00 = byte, 01 = half, 10 = word
//   wb_sel        write-back: 00 = ALU, 01 = MEM, 10 = PC+4
//   pc_sel        next PC: 00 = PC+4, 01 = PC+imm, 10 = ALU with bit0 cleared
//   trap          high while in TRAP
//   state         current state encoding (debug)

module mc_control_unit #(
    parameter int N       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] instr,
    input  logic         mem_ready,
    input  logic         branch_taken,
    output logic         pc_write,
    output logic         ir_write,
    output logic         reg_write,
    output logic         mem_req,
    output logic         mem_we,
    output logic         mem_addr_sel,
    output logic [1:0]   alu_src_a,
    output logic [1:0]   alu_src_b,
    output logic [1:0]   alu_op,
    output logic [1:0]   save_method,
    output logic [1:0]   wb_sel,
    output logic [1:0]   pc_sel,
    output logic         trap,
    output logic [2:0]   state
);

    // A disabled timeout still needs a one-bit counter to keep widths legal.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    state_t          cur_state;
    state_t          next_state;
    logic [CW-1:0]   wait_cnt;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_r, is_i, is_load, is_store, is_branch;
    logic            is_jal, is_jalr, is_lui, is_auipc;
    logic            legal;
    logic            timed_out;
    logic            unused_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Register fields and any bits above 31 are consumed by the datapath.
    assign unused_bits = ^{instr[N-1:15], instr[11:7]};

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);

    // Stores wider than a word (funct3 > 010) are not supported.
    assign legal = (instr[1:0] == 2'b11)
                 && (is_r | is_i | is_load | is_store | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc)
                 && !(is_store && (funct3 > 3'b010));

    // The timeout fires when the counter has already absorbed TIMEOUT wait
    // cycles; a mem_ready arriving in that cycle is still accepted.
    assign timed_out = (TIMEOUT > 0) && (wait_cnt == WAIT_MAX);

    assign state = rst_n ? cur_state : S_FETCH;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    // Wait counter: cleared on any state change (so on every entry to
    // FETCH or MEM), saturating so a disabled timeout can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (next_state != cur_state) begin
            wait_cnt <= '0;
        end else if ((cur_state == S_FETCH || cur_state == S_MEM) &&
                     !mem_ready && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Next-state and output decode.
    always_comb begin
        next_state   = cur_state;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        save_method  = 2'b00;
        wb_sel       = 2'b00;
        pc_sel       = 2'b00;
        trap         = 1'b0;

        case (cur_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    next_state = S_DECODE;
                end else if (timed_out) begin
                    next_state = S_TRAP;
                end
            end

            S_DECODE: begin
                next_state = legal ? S_EXEC : S_TRAP;
            end

            S_EXEC: begin
                if (is_r) begin
                    alu_op     = 2'b10;
                    next_state = S_WB;
                end else if (is_i) begin
                    alu_src_b  = 2'b01;
                    alu_op     = 2'b10;
                    next_state = S_WB;
                end else if (is_load || is_store) begin
                    alu_src_b  = 2'b01;
                    next_state = S_MEM;
                end else if (is_lui) begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b01;
                    next_state = S_WB;
                end else if (is_auipc) begin
                    alu_src_a  = 2'b01;
                    alu_src_b  = 2'b01;
                    next_state = S_WB;
                end else if (is_branch) begin
                    alu_op     = 2'b01;
                    pc_write   = 1'b1;
                    pc_sel     = branch_taken ? 2'b01 : 2'b00;
                    next_state = S_FETCH;
                end else if (is_jal || is_jalr) begin
                    alu_src_b  = 2'b01;
                    next_state = S_WB;
                end else begin
                    // Only reachable if the IR changed after DECODE.
                    next_state = S_TRAP;
                end
            end

            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                case (funct3)
                    3'b000:  save_method = 2'b00;
                    3'b001:  save_method = 2'b01;
                    3'b010:  save_method = 2'b10;
                    default: save_method = 2'b00;
                endcase
                if (mem_ready) begin
                    if (is_load) begin
                        next_state = S_WB;
                    end else if (is_store) begin
                        pc_write   = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_TRAP;
                    end
                end else if (timed_out) begin
                    next_state = S_TRAP;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                if (is_load) begin
                    wb_sel = 2'b01;
                end else if (is_jal || is_jalr) begin
                    wb_sel = 2'b10;
                end
                if (is_jal) begin
                    pc_sel = 2'b01;
                end else if (is_jalr) begin
                    pc_sel = 2'b10;
                end
                next_state = S_FETCH;
            end

            S_TRAP: begin
                trap = 1'b1;
            end

            default: begin
                next_state = S_TRAP;
            end
        endcase

        // Reset silences every output immediately, not just at the next edge.
        if (!rst_n) begin
            pc_write     = 1'b0;
            ir_write     = 1'b0;
            reg_write    = 1'b0;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            alu_src_a    = 2'b00;
            alu_src_b    = 2'b00;
            alu_op       = 2'b00;
            save_method  = 2'b00;
            wb_sel       = 2'b00;
            pc_sel       = 2'b00;
            trap         = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit
//
// Bench for mc_control_unit (TIMEOUT = 4). A table of hand-written cycle
// vectors covers the directed sequences, then a randomized run is compared
// cycle by cycle against an instruction-class reference model.

module tb_mc_control_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        pc_write, ir_write, reg_write, mem_req, mem_we, mem_addr_sel;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, save_method, wb_sel, pc_sel;
    logic        trap;
    logic [2:0]  state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mc_control_unit #(.N(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .pc_write(pc_write), .ir_write(ir_write),
        .reg_write(reg_write), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .save_method(save_method),
        .wb_sel(wb_sel), .pc_sel(pc_sel), .trap(trap), .state(state)
    );

    // Output bundle: state, trap, pcw, irw, rw, mreq, mwe, mas, a, b, op, sm, wb, ps
    logic [21:0] dut_vec;
    assign dut_vec = {state, trap, pc_write, ir_write, reg_write, mem_req,
                      mem_we, mem_addr_sel, alu_src_a, alu_src_b, alu_op,
                      save_method, wb_sel, pc_sel};

    function automatic logic [21:0] mk(input int st, tr, pcw, irw, rw, mreq,
                                       mwe, mas, a, b, op, sm, wb, ps);
        return {3'(st), 1'(tr), 1'(pcw), 1'(irw), 1'(rw), 1'(mreq), 1'(mwe),
                1'(mas), 2'(a), 2'(b), 2'(op), 2'(sm), 2'(wb), 2'(ps)};
    endfunction

    task automatic check_output(input string name, input logic [21:0] act,
                                input logic [21:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h (state got %0d exp %0d)",
                     name, act, exp, act[21:19], exp[21:19]);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic        rdy;
        logic        tk;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [31:0] i, input logic rd,
                       input logic tk, input logic [21:0] e);
        vec_t v;
        v.rst = r; v.ins = i; v.rdy = rd; v.tk = tk; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input logic r, input logic [31:0] i,
                                  input logic rd, input logic tk);
        @(negedge clk);
        rst_n = r;
        instr = i;
        mem_ready = rd;
        branch_taken = tk;
        #1;
    endtask

    // ---------------- reference model ----------------
    // Instruction classes: 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL,
    // 6 JALR, 7 LUI, 8 AUIPC, 9 illegal.
    logic [6:0] ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                           7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                           7'b0010111};
    int ex_a[10]    = '{0, 0, 0, 0, 0, 0, 0, 2, 1, 0};
    int ex_b[10]    = '{0, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int ex_op[10]   = '{2, 2, 0, 0, 1, 0, 0, 0, 0, 0};
    int ex_next[10] = '{4, 4, 3, 3, 0, 4, 4, 4, 4, 7};

    function automatic int kind_of(input logic [31:0] ins);
        int k = 9;
        for (int j = 0; j < 9; j++)
            if (ins[6:0] == ops[j]) k = j;
        if (k == 3 && ins[14:12] > 3'd2) k = 9;
        return k;
    endfunction

    function automatic void model(input int st, input logic [31:0] ins,
                                  input logic rdy, input logic tk,
                                  input int waited, output logic [21:0] exp,
                                  output int nxt);
        int tr = 0, pcw = 0, irw = 0, rw = 0, mreq = 0, mwe = 0, mas = 0;
        int a = 0, b = 0, op = 0, sm = 0, wb = 0, ps = 0;
        int k = kind_of(ins);
        int f3 = int'(ins[14:12]);
        bool_timeout: begin end
        nxt = st;
        case (st)
            0: begin
                mreq = 1;
                if (rdy) begin irw = 1; nxt = 1; end
                else if (TO > 0 && waited >= TO) nxt = 7;
            end
            1: nxt = (k == 9) ? 7 : 2;
            2: begin
                a = ex_a[k]; b = ex_b[k]; op = ex_op[k]; nxt = ex_next[k];
                if (k == 4) begin pcw = 1; ps = tk ? 1 : 0; end
            end
            3: begin
                mreq = 1; mas = 1; mwe = (k == 3) ? 1 : 0;
                sm = (f3 <= 2) ? f3 : 0;
                if (rdy) begin
                    if (k == 2) nxt = 4;
                    else begin pcw = 1; nxt = 0; end
                end else if (TO > 0 && waited >= TO) nxt = 7;
            end
            4: begin
                rw = 1; pcw = 1; nxt = 0;
                wb = (k == 2) ? 1 : (k == 5 || k == 6) ? 2 : 0;
                ps = (k == 5) ? 1 : (k == 6) ? 2 : 0;
            end
            default: tr = 1;
        endcase
        exp = mk(st, tr, pcw, irw, rw, mreq, mwe, mas, a, b, op, sm, wb, ps);
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] v = $urandom;
        int k = $urandom_range(0, 9);
        if (k < 9) v[6:0] = ops[k];
        if (k == 3) v[14:12] = 3'($urandom_range(0, 3));
        return v;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ADD   = 32'h002081B3;
        logic [31:0] BEQ   = 32'h00208463;
        logic [31:0] SH    = 32'h00209023;
        logic [31:0] FENCE = 32'h0000000F;
        logic [31:0] SBAD  = 32'h0020B023;
        logic [31:0] SW    = 32'h0020A023;
        logic [21:0] f_rdy  = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        logic [21:0] f_wait = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        logic [21:0] dec    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        logic [21:0] trp    = mk(7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        logic [21:0] sh_mem = mk(3, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0);
        logic [21:0] ex_mem = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        int m_st, m_wait, nxt;
        logic [21:0] exp;

        // ADD, zero wait
        add(0, ADD, 0, 0, 22'd0);
        add(1, ADD, 1, 0, f_rdy);
        add(1, ADD, 0, 0, dec);
        add(1, ADD, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        add(1, ADD, 0, 0, mk(4, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // BEQ taken (mem_ready high in EXEC must be ignored), then not taken
        add(1, BEQ, 1, 0, f_rdy);
        add(1, BEQ, 0, 0, dec);
        add(1, BEQ, 1, 1, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        add(1, BEQ, 1, 0, f_rdy);
        add(1, BEQ, 0, 0, dec);
        add(1, BEQ, 0, 0, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // SH with mem_ready delayed 3 cycles
        add(1, SH, 1, 0, f_rdy);
        add(1, SH, 0, 0, dec);
        add(1, SH, 0, 0, ex_mem);
        add(1, SH, 0, 0, sh_mem);
        add(1, SH, 0, 0, sh_mem);
        add(1, SH, 0, 0, sh_mem);
        add(1, SH, 1, 0, mk(3, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0));
        // Illegal opcode traps from DECODE; TRAP is absorbing
        add(1, FENCE, 1, 0, f_rdy);
        add(1, FENCE, 0, 0, dec);
        add(1, FENCE, 1, 0, trp);
        add(1, FENCE, 1, 0, trp);
        // STORE funct3=011 traps from DECODE
        add(0, SBAD, 0, 0, 22'd0);
        add(1, SBAD, 1, 0, f_rdy);
        add(1, SBAD, 0, 0, dec);
        add(1, SBAD, 0, 0, trp);
        // FETCH timeout
        add(0, ADD, 0, 0, 22'd0);
        for (int i = 0; i < 5; i++) add(1, ADD, 0, 0, f_wait);
        add(1, ADD, 1, 0, trp);
        // mem_ready on the timeout cycle wins; then reset in MEM of a store
        add(0, SW, 0, 0, 22'd0);
        for (int i = 0; i < 4; i++) add(1, SW, 0, 0, f_wait);
        add(1, SW, 1, 0, f_rdy);
        add(1, SW, 0, 0, dec);
        add(1, SW, 0, 0, ex_mem);
        add(1, SW, 0, 0, mk(3, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 2, 0, 0));
        add(0, SW, 1, 0, 22'd0);
        add(1, SW, 0, 0, f_wait);

        #2;
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst, vecs[i].ins, vecs[i].rdy, vecs[i].tk);
            check_output($sformatf("vec%0d", i), dut_vec, vecs[i].exp);
        end

        // Randomized run against the model
        apply_stimulus(0, 32'h0, 0, 0);
        m_st = 0;
        m_wait = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic r;
            logic [31:0] ins;
            if (m_st == 7) r = ($urandom_range(0, 2) == 0);
            else r = ($urandom_range(0, 60) != 0);
            ins = (m_st == 0) ? gen_instr() : instr;
            apply_stimulus(r, ins, ($urandom_range(0, 9) < 6), 1'($urandom));
            if (!rst_n) begin
                m_st = 0;
                m_wait = 0;
                exp = 22'd0;
                nxt = 0;
            end else begin
                model(m_st, instr, mem_ready, branch_taken, m_wait, exp, nxt);
            end
            check_output("rand", dut_vec, exp);
            if (rst_n) begin
                if (nxt != m_st) m_wait = 0;
                else if ((m_st == 0 || m_st == 3) && !mem_ready) m_wait++;
                m_st = nxt;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
